// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of a 1G MAC TX AXI-stream port.
// Optional mid-frame stall watchdog: define ETH_TX_ARB_WATCHDOG_EN.
module eth_tx_frame_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int STALL_LIMIT = 64,
   localparam int ID_W       = $clog2(NUM_PORTS)
) (
   input  logic                   tx_clk,
   input  logic                   tx_rst,
   input  logic                   enable,
   input  logic [8*NUM_PORTS-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
   output logic [NUM_PORTS-1:0]   s_axis_tready,
   input  logic [NUM_PORTS-1:0]   s_axis_tlast,
   input  logic [NUM_PORTS-1:0]   s_axis_tuser,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   grant_valid,
   output logic [ID_W-1:0]        grant_id,
   output logic                   frame_done,
   output logic                   frame_abort
);

   if (NUM_PORTS < 2 || NUM_PORTS > 8 ||
       STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_cfg
      $error("eth_tx_frame_arbiter: parameter out of range");
   end

`ifdef ETH_TX_ARB_WATCHDOG_EN
   typedef enum logic [1:0] {
      ST_IDLE, ST_BUSY, ST_ABORT, ST_DRAIN
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_IDLE, ST_BUSY
   } state_t;
`endif

   state_t          state_q, state_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic            grant_valid_q;
   logic            done_q, done_d;
   logic            found;
   logic [ID_W-1:0] pick, idx;
   logic            g_valid, g_last, g_user;
   logic [7:0]      g_data;

   assign g_valid = s_axis_tvalid[grant_id_q];
   assign g_last  = s_axis_tlast[grant_id_q];
   assign g_user  = s_axis_tuser[grant_id_q];
   assign g_data  = s_axis_tdata[{grant_id_q, 3'b000} +: 8];

   // Round-robin search starting just after the last granted source.
   always_comb begin
      found = 1'b0;
      pick  = grant_id_q;
      idx   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = ID_W'((int'(grant_id_q) + k) % NUM_PORTS);
         if (!found && s_axis_tvalid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

`ifdef ETH_TX_ARB_WATCHDOG_EN
   logic [7:0] stall_q, stall_d;
   logic       abort_q, abort_d;
`endif

   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      done_d        = 1'b0;
      m_axis_tdata  = 8'h00;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      stall_d       = stall_q;
      abort_d       = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
`ifdef ETH_TX_ARB_WATCHDOG_EN
            stall_d = 8'h00;
`endif
            if (enable && found) begin
               grant_id_d = pick;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            m_axis_tdata              = g_data;
            m_axis_tvalid             = g_valid;
            m_axis_tlast              = g_last;
            m_axis_tuser              = g_user;
            s_axis_tready[grant_id_q] = m_axis_tready;
            if (g_valid && m_axis_tready && g_last) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
`ifdef ETH_TX_ARB_WATCHDOG_EN
            if (g_valid) begin
               stall_d = 8'h00;
            end else begin
               stall_d = stall_q + 8'd1;
               if (stall_d == 8'(STALL_LIMIT)) state_d = ST_ABORT;
            end
`endif
         end
`ifdef ETH_TX_ARB_WATCHDOG_EN
         // Poisoned terminator so the MAC drops the partial frame.
         ST_ABORT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            if (m_axis_tready) begin
               abort_d = 1'b1;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            s_axis_tready[grant_id_q] = 1'b1;
            if (g_valid && g_last) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         state_q       <= ST_IDLE;
         grant_id_q    <= ID_W'(NUM_PORTS - 1);
         grant_valid_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= (state_d != ST_IDLE);
         done_q        <= done_d;
      end
   end

`ifdef ETH_TX_ARB_WATCHDOG_EN
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         stall_q <= 8'h00;
         abort_q <= 1'b0;
      end else begin
         stall_q <= stall_d;
         abort_q <= abort_d;
      end
   end
   assign frame_abort = abort_q;
`else
   assign frame_abort = 1'b0;
`endif

   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign frame_done  = done_q;

endmodule
